// File: rtl/auto_human_player.sv
// Automated human opponent for the 15-game controller: starts a game, answers each computer move
// with a legal pick and drives the enter_L handshake. Define STRATEGY_EN for win/block/centre picking.
module auto_human_player #(
  parameter int PRESS_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic [3:0] cMove,
  input  logic       win,
  output logic [3:0] hMove,
  output logic       enter_L,
  output logic       newGame_L,
  output logic       busy,
  output logic       done,
  output logic       timedOut,
  output logic [8:0] hMask,
  output logic [8:0] cMask
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NEWG  = 3'd1;
  localparam logic [2:0] S_WAITC = 3'd2;
  localparam logic [2:0] S_PICK  = 3'd3;
  localparam logic [2:0] S_SETUP = 3'd4;
  localparam logic [2:0] S_PRESS = 3'd5;
  localparam logic [2:0] S_REL   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [3:0] hmove_q, hmove_d, lastc_q, lastc_d, cnt_q, cnt_d;
  logic [8:0] hmask_q, hmask_d, cmask_q, cmask_d;
  logic [7:0] tmo_q, tmo_d;
  logic       tout_q, tout_d, winseen_q, winseen_d;

  // Triple t is hit when it holds bit b and every member of t is present in m.
  function automatic logic hit(input logic [8:0] m, input logic [8:0] b, input logic [8:0] t);
    return ((t & b) != 9'd0) && ((m & t) == t);
  endfunction

  // The eight 3-subsets of 1..9 summing to 15, restricted to those containing b.
  function automatic logic line_hit(input logic [8:0] m, input logic [8:0] b);
    return hit(m, b, 9'h111) || hit(m, b, 9'h0A1) || hit(m, b, 9'h10A) || hit(m, b, 9'h092) ||
           hit(m, b, 9'h062) || hit(m, b, 9'h08C) || hit(m, b, 9'h054) || hit(m, b, 9'h038);
  endfunction

  function automatic logic [3:0] complete_n(input logic [8:0] own, input logic [8:0] taken);
    logic [3:0] n;
    logic [8:0] b;
    n = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      b = 9'd1 << i;
      if ((taken & b) == 9'd0 && line_hit(own | b, b)) n = 4'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [3:0] pick_n(input logic [8:0] hm, input logic [8:0] cm);
    logic [8:0] taken;
    logic [3:0] lowest;
`ifdef STRATEGY_EN
    logic [3:0] w, bl;
`endif
    taken  = hm | cm;
    lowest = 4'd0;
    for (int i = 8; i >= 0; i--)
      if ((taken & (9'd1 << i)) == 9'd0) lowest = 4'(i + 1);
`ifdef STRATEGY_EN
    w  = complete_n(hm, taken);
    bl = complete_n(cm, taken);
    if (w != 4'd0)                 return w;
    else if (bl != 4'd0)           return bl;
    else if (taken[4] == 1'b0)     return 4'd5;
    else                           return lowest;
`else
    return lowest;
`endif
  endfunction

  logic [8:0] cbit, hbit, cmask_new;
  logic       new_mv, full;
  logic [3:0] pick_w;

  assign cbit      = 9'd1 << (cMove - 4'd1);
  assign hbit      = 9'd1 << (hmove_q - 4'd1);
  assign cmask_new = cmask_q | cbit;
  // Compare against lastC rather than edge-detect so a move posted outside WAIT_C is still seen.
  assign new_mv    = (cMove != 4'd0) && (cMove <= 4'd9) && (cMove != lastc_q) &&
                     ((cmask_q & cbit) == 9'd0);
  assign full      = &(hmask_q | cmask_q);
  assign pick_w    = pick_n(hmask_q, cmask_q);

  always_comb begin
    state_d   = state_q;
    hmove_d   = hmove_q;
    lastc_d   = lastc_q;
    cnt_d     = cnt_q;
    hmask_d   = hmask_q;
    cmask_d   = cmask_q;
    tmo_d     = tmo_q;
    tout_d    = tout_q;
    winseen_d = winseen_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d   = S_NEWG;
        hmask_d   = 9'd0;
        cmask_d   = 9'd0;
        lastc_d   = 4'd0;
        tout_d    = 1'b0;
        cnt_d     = 4'd0;
        tmo_d     = 8'd0;
        winseen_d = 1'b0;
      end
      S_NEWG: begin
        state_d = S_WAITC;
        tmo_d   = 8'd0;
      end
      S_WAITC: begin
        if (new_mv) begin
          cmask_d = cmask_new;
          lastc_d = cMove;
          tmo_d   = 8'd0;
          state_d = (win || line_hit(cmask_new, 9'h1FF)) ? S_DONE : S_PICK;
        end else if (win) begin
          state_d = S_DONE;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_PICK: begin
        if (win || full) state_d = S_DONE;
        else begin
          hmove_d = pick_w;
          cnt_d   = 4'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (win) state_d = S_DONE;
        else if (cnt_q == 4'(GAP_CYC - 1)) begin
          cnt_d   = 4'd0;
          hmask_d = hmask_q | hbit;
          state_d = S_PRESS;
        end else cnt_d = cnt_q + 4'd1;
      end
      // A press in flight always completes so enter_L is never abandoned low.
      S_PRESS: begin
        if (win) winseen_d = 1'b1;
        if (cnt_q == 4'(PRESS_CYC - 1)) begin
          cnt_d   = 4'd0;
          state_d = S_REL;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_REL: begin
        if (win) winseen_d = 1'b1;
        if (cnt_q == 4'(GAP_CYC - 1)) begin
          cnt_d   = 4'd0;
          tmo_d   = 8'd0;
          state_d = (winseen_q || win) ? S_DONE : S_WAITC;
        end else cnt_d = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      hmove_q   <= 4'd0;
      lastc_q   <= 4'd0;
      cnt_q     <= 4'd0;
      hmask_q   <= 9'd0;
      cmask_q   <= 9'd0;
      tmo_q     <= 8'd0;
      tout_q    <= 1'b0;
      winseen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hmove_q   <= hmove_d;
      lastc_q   <= lastc_d;
      cnt_q     <= cnt_d;
      hmask_q   <= hmask_d;
      cmask_q   <= cmask_d;
      tmo_q     <= tmo_d;
      tout_q    <= tout_d;
      winseen_q <= winseen_d;
    end
  end

  assign hMove     = hmove_q;
  assign enter_L   = (state_q != S_PRESS);
  assign newGame_L = (state_q != S_NEWG);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign timedOut  = tout_q;
  assign hMask     = hmask_q;
  assign cMask     = cmask_q;

endmodule

// File: tb/tb_auto_human_player.sv
// Scoreboard bench for auto_human_player: expected picks queued as computer moves are driven,
// popped when the DUT presses enter_L.
module tb_auto_human_player;
  localparam int PRESS_CYC = 2;
  localparam int GAP_CYC   = 1;
  localparam int TIMEOUT   = 255;

  logic       clock = 1'b0, reset_L = 1'b0, start = 1'b0, win = 1'b0;
  logic [3:0] cMove = 4'd0;
  logic [3:0] hMove;
  logic       enter_L, newGame_L, busy, done, timedOut;
  logic [8:0] hMask, cMask;

  always #5 clock = ~clock;

  auto_human_player #(.PRESS_CYC(PRESS_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .cMove(cMove), .win(win),
    .hMove(hMove), .enter_L(enter_L), .newGame_L(newGame_L), .busy(busy), .done(done),
    .timedOut(timedOut), .hMask(hMask), .cMask(cMask)
  );

  typedef struct { int hmove; int hmask; int cmask; } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_err = 0;
  logic [8:0] mh = 9'd0, mc = 9'd0;
  int prev_h = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit has(input logic [8:0] m, input int n);
    return ((m >> (n - 1)) & 9'd1) != 9'd0;
  endfunction

  function automatic bit m_triple(input logic [8:0] m);
    for (int a = 1; a <= 9; a++)
      for (int b = a + 1; b <= 9; b++)
        for (int c = b + 1; c <= 9; c++)
          if (a + b + c == 15 && has(m, a) && has(m, b) && has(m, c)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_complete(input logic [8:0] own, input logic [8:0] taken);
    for (int n = 1; n <= 9; n++)
      if (!has(taken, n))
        for (int a = 1; a <= 9; a++)
          for (int b = a + 1; b <= 9; b++)
            if (has(own, a) && has(own, b) && a + b + n == 15) return n;
    return 0;
  endfunction

  function automatic int m_pick(input logic [8:0] hm, input logic [8:0] cm);
    logic [8:0] taken;
    taken = hm | cm;
`ifdef STRATEGY_EN
    if (m_complete(hm, taken) != 0) return m_complete(hm, taken);
    if (m_complete(cm, taken) != 0) return m_complete(cm, taken);
    if (!has(taken, 5)) return 5;
`endif
    for (int n = 1; n <= 9; n++) if (!has(taken, n)) return n;
    return 0;
  endfunction

  task automatic new_game();
    int lows;
    cMove = 4'd0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("newgame_hmask", int'(hMask), 0);
    chk("newgame_cmask", int'(cMask), 0);
    chk("newgame_timedout", int'(timedOut), 0);
    lows = (newGame_L == 1'b0) ? 1 : 0;
    repeat (2) begin
      @(negedge clock);
      if (newGame_L == 1'b0) lows++;
    end
    chk("newgame_pulse", lows, 1);
    mh = 9'd0;
    mc = 9'd0;
  endtask

  // Drive one computer move; either expect the game to end or a press carrying the model's pick.
  task automatic cmove(input int c, input bit rst_mid, input bit win_mid);
    exp_t e;
    int p, setup, lows;
    bit seen;
    cMove = 4'(c);
    mc = mc | (9'd1 << (c - 1));
    if (m_triple(mc)) begin
      lows = 0;
      for (int g = 0; g < 10 && !done; g++) begin
        @(negedge clock);
        if (!enter_L) lows++;
      end
      chk("triple_done", int'(done), 1);
      chk("triple_nopress", lows, 0);
      chk("triple_cmask", int'(cMask), int'(mc));
      chk("triple_hmask", int'(hMask), int'(mh));
      return;
    end
    p  = m_pick(mh, mc);
    mh = mh | (9'd1 << (p - 1));
    e.hmove = p; e.hmask = int'(mh); e.cmask = int'(mc);
    sbq.push_back(e);
    setup = 0;
    seen  = 1'b0;
    for (int g = 0; g < 60; g++) begin
      @(negedge clock);
      if (!enter_L) begin seen = 1'b1; break; end
      if (int'(hMove) == sbq[0].hmove) setup++; else setup = 0;
    end
    chk("press_seen", int'(seen), 1);
    e = sbq.pop_front();
    if (!seen) return;
    chk("press_hmove", int'(hMove), e.hmove);
    chk("press_hmask", int'(hMask), e.hmask);
    chk("press_cmask", int'(cMask), e.cmask);
    if (p != prev_h) chk("setup_gap", setup, GAP_CYC);
    prev_h = p;
    if (rst_mid) begin
      #2 reset_L = 1'b0;
      #1;
      chk("rst_enter_L", int'(enter_L), 1);
      chk("rst_hmove", int'(hMove), 0);
      chk("rst_hmask", int'(hMask), 0);
      chk("rst_cmask", int'(cMask), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_newgame_L", int'(newGame_L), 1);
      @(negedge clock);
      reset_L = 1'b1;
      mh = 9'd0; mc = 9'd0; prev_h = 0;
      return;
    end
    if (win_mid) win = 1'b1;
    lows = 1;
    for (int g = 0; g < 20; g++) begin
      @(negedge clock);
      if (enter_L) break;
      lows++;
    end
    chk("press_len", lows, PRESS_CYC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows;
    @(negedge clock);
    chk("reset_hmove", int'(hMove), 0);
    chk("reset_enter_L", int'(enter_L), 1);
    chk("reset_newgame_L", int'(newGame_L), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_timedout", int'(timedOut), 0);
    chk("reset_masks", int'({hMask, cMask}), 0);
    reset_L = 1'b1;

    // Game A: start ignored while busy, two normal moves, then reset in the middle of a press.
    new_game();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lows = 0;
    repeat (3) begin
      if (!newGame_L) lows++;
      @(negedge clock);
    end
    chk("busy_start_ignored", lows, 0);
    chk("busy_in_waitc", int'(busy), 1);
    cmove(5, 1'b0, 1'b0);
    cmove(4, 1'b0, 1'b0);
    cmove(3, 1'b1, 1'b0);

    // Game B: three moves, then repeated/illegal cMove until the timeout fires.
    new_game();
    cmove(5, 1'b0, 1'b0);
    cmove(2, 1'b0, 1'b0);
    cmove(7, 1'b0, 1'b0);
    n = 0; lows = 0;
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
      if (n == 20) cMove = 4'd12;
      if (!enter_L) lows++;
    end
    chk("timeout_cycles", n, GAP_CYC + TIMEOUT);
    chk("timeout_flag", int'(timedOut), 1);
    chk("timeout_done", int'(done), 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_nopress", lows, 0);

    // Game C: win raised during a press; the press completes, then DONE.
    new_game();
    cmove(5, 1'b0, 1'b1);
    @(negedge clock);
    chk("win_done", int'(done), 1);
    chk("win_enter_L", int'(enter_L), 1);
    chk("win_hmask", int'(hMask), int'(mh));
    win = 1'b0;

    // Game D: computer completes a 15-triple and the block stops without answering.
    new_game();
`ifdef STRATEGY_EN
    cmove(2, 1'b0, 1'b0);
    cmove(4, 1'b0, 1'b0);
    cmove(8, 1'b0, 1'b0);
    cmove(3, 1'b0, 1'b0);
`else
    cmove(5, 1'b0, 1'b0);
    cmove(4, 1'b0, 1'b0);
    cmove(6, 1'b0, 1'b0);
`endif
    chk("triple_timedout", int'(timedOut), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
